// File: rtl/cr_cg_ob_sfwd_pkg.sv
// Shared types for the CG outbound store-and-forward buffer.
package cr_cgPKG;

  // AXI4-stream data-path beat as carried between CG blocks.
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic        tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  // Single-cycle event pulses from the store-and-forward buffer.
  typedef struct packed {
    logic frame_out;
    logic cut_thru;
    logic beat_in;
  } sfwd_stats_t;

  localparam int SFWD_ENTRY_W = 82;

  typedef enum logic [1:0] {
    HOLD,
    SEND,
    CUT
  } sfwd_mode_e;

  // One stored beat; tvalid is implied by occupancy and never stored.
  typedef struct packed {
    logic        tlast;
    logic        tid;
    logic [7:0]  tstrb;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } sfwd_entry_t;

  function automatic sfwd_entry_t sfwd_to_entry(input axi4s_dp_bus_t b);
    sfwd_entry_t e;
    e.tlast = b.tlast;
    e.tid   = b.tid;
    e.tstrb = b.tstrb;
    e.tuser = b.tuser;
    e.tdata = b.tdata;
    return e;
  endfunction

endpackage

// File: rtl/cr_cg_ob_sfwd_fifo.sv
// Flop-array FIFO with wrap-bit pointers; head entry is read combinationally.
module cr_cg_ob_sfwd_fifo
  import cr_cgPKG::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_i,
  input  sfwd_entry_t            wr_data_i,
  input  logic                   rd_i,
  output sfwd_entry_t            head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  sfwd_entry_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  // Storage write; the caller only writes when not full.
  // NOTE: storage carries no reset -- stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // Pointer advance; natural binary wrap gives the extra wrap bit for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_i) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign head_o      = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/cr_cg_ob_sfwd.sv
// Store-and-forward frame buffer: holds each frame until its tlast beat is in,
// then releases it as one burst; an oversize frame falls back to cut-through.
module cr_cg_ob_sfwd
  import cr_cgPKG::*;
#(
  parameter int DEPTH     = 16,
  parameter int STUB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  axi4s_dp_bus_t          cg_ob_out,
  output axi4s_dp_rdy_t          sfwd_ib_out,
  output axi4s_dp_bus_t          sfwd_ob_out,
  input  axi4s_dp_rdy_t          sfwd_ob_in,
  output sfwd_stats_t            sfwd_stat_events,
  output logic [$clog2(DEPTH):0] sfwd_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic        [AW:0] cf_cnt_q, cf_cnt_d;
  sfwd_mode_e         mode_q, mode_d;
  sfwd_stats_t        stats_q;
  logic               rdy_q;
  sfwd_entry_t        head;
  logic        [AW:0] occ;
  logic               full, empty, in_rdy, out_vld, cut_start;
  logic               wr, rd, wr_tlast, rd_tlast;

  cr_cg_ob_sfwd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_i        (wr),
    .wr_data_i   (sfwd_to_entry(cg_ob_out)),
    .rd_i        (rd),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .occupancy_o (occ)
  );

  // tready is purely registered state: low through reset, then !full.
  assign in_rdy   = rdy_q & ~full;
  assign wr       = cg_ob_out.tvalid & in_rdy;
  assign rd       = out_vld & sfwd_ob_in.tready;
  assign wr_tlast = wr & cg_ob_out.tlast;
  assign rd_tlast = rd & head.tlast;

  // Complete-frame count: tlast written in, tlast read out.
  always_comb begin
    cf_cnt_d = cf_cnt_q;
    unique case ({wr_tlast, rd_tlast})
      2'b10:   cf_cnt_d = cf_cnt_q + CNT_ONE;
      2'b01:   cf_cnt_d = cf_cnt_q - CNT_ONE;
      default: cf_cnt_d = cf_cnt_q;
    endcase
  end

  // Release FSM: next mode, outbound valid and the cut-through trigger.
  always_comb begin
    mode_d    = mode_q;
    out_vld   = 1'b0;
    cut_start = 1'b0;
    unique case (mode_q)
      HOLD: begin
        out_vld = (cf_cnt_q != '0) & ~empty;
        if (cf_cnt_q != '0 && !empty) begin
          mode_d = SEND;
        end else if (full && cf_cnt_q == '0) begin
          mode_d    = CUT;
          cut_start = 1'b1;
        end
      end
      SEND:    out_vld = ~empty;
      CUT:     out_vld = ~empty;
      default: mode_d  = HOLD;
    endcase
    // Leaving a frame: continue straight into the next complete one if present.
    if (rd_tlast) mode_d = (cf_cnt_d != '0) ? SEND : HOLD;
  end

  // State, frame count, ready flag and registered stats pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= HOLD;
      cf_cnt_q <= '0;
      rdy_q    <= 1'b0;
      stats_q  <= '0;
    end else begin
      mode_q            <= mode_d;
      cf_cnt_q          <= cf_cnt_d;
      rdy_q             <= 1'b1;
      stats_q.frame_out <= rd_tlast;
      stats_q.cut_thru  <= cut_start;
      stats_q.beat_in   <= wr;
    end
  end

  // Frame-count sanity: never read a tlast that was not counted, never exceed DEPTH.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(rd_tlast && !wr_tlast && cf_cnt_q == '0));
      assert (cf_cnt_q <= (AW+1)'(DEPTH));
    end
  end

  // Output selection: buffered path, or plain wire-through in stub builds.
  always_comb begin
    if (STUB_MODE != 0) begin
      sfwd_ob_out      = cg_ob_out;
      sfwd_ib_out      = sfwd_ob_in;
      sfwd_stat_events = '0;
      sfwd_occupancy   = '0;
    end else begin
      sfwd_ob_out.tvalid = out_vld;
      sfwd_ob_out.tlast  = head.tlast;
      sfwd_ob_out.tid    = head.tid;
      sfwd_ob_out.tstrb  = head.tstrb;
      sfwd_ob_out.tuser  = head.tuser;
      sfwd_ob_out.tdata  = head.tdata;
      sfwd_ib_out.tready = in_rdy;
      sfwd_stat_events   = stats_q;
      sfwd_occupancy     = occ;
    end
  end

endmodule
